// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronises and glitch-filters the PS/2 pins and decodes
// 11-bit frames into scan-code bytes. It also flags the keyboard BAT code for the reset sequencer.
module ps2_receiver #(
    parameter int          FILTER_LEN    = 4,
    parameter int          TIMEOUT_COUNT = 5000,
    parameter int          TIMEOUT_WIDTH = 13,
    parameter logic [7:0]  BAT_CODE      = 8'hAA
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       inhibit,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       reset_required,
    output logic       busy
);

    localparam int FILT_W = $clog2(FILTER_LEN);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Two-flop synchronisers; both lines idle high.
    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       clk_s;
    logic       data_s;

    logic              clk_f_q, clk_f_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_q, fall_d;

    state_e                   state_q, state_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [7:0]               shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;

    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       parity_error_q, parity_error_d;
    logic       frame_error_q, frame_error_d;
    logic       reset_required_q, reset_required_d;
    logic       busy_q, busy_d;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Synchroniser, glitch filter and falling-edge detector.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_f_d     = clk_f_q;
        filt_cnt_d  = '0;
        if (clk_s != clk_f_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                clk_f_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        // Registered together with clk_f, so fall is high in the first cycle clk_f reads 0.
        fall_d = clk_f_q & ~clk_f_d;
    end

    // Frame decoder; all outputs are computed here and registered.
    always_comb begin
        state_d          = state_q;
        bit_idx_d        = bit_idx_q;
        shift_d          = shift_q;
        parity_d         = parity_q;
        to_cnt_d         = to_cnt_q;
        data_out_d       = data_out_q;
        data_valid_d     = 1'b0;
        parity_error_d   = 1'b0;
        frame_error_d    = 1'b0;
        reset_required_d = 1'b0;

        if (inhibit) begin
            state_d  = IDLE;
            to_cnt_d = '0;
        end else if (fall_q) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                        shift_d   = '0;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d[bit_idx_q] = data_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    data_out_d = shift_q;
                    state_d    = IDLE;
                    if (!data_s) begin
                        frame_error_d = 1'b1;
                    end else if (^{shift_q, parity_q}) begin
                        data_valid_d     = 1'b1;
                        reset_required_d = (shift_q == BAT_CODE);
                    end else begin
                        parity_error_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_COUNT - 1)) begin
            state_d       = IDLE;
            to_cnt_d      = '0;
            frame_error_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q       <= '1;
            data_sync_q      <= '1;
            clk_f_q          <= 1'b1;
            filt_cnt_q       <= '0;
            fall_q           <= 1'b0;
            state_q          <= IDLE;
            bit_idx_q        <= '0;
            shift_q          <= '0;
            parity_q         <= 1'b0;
            to_cnt_q         <= '0;
            data_out_q       <= '0;
            data_valid_q     <= 1'b0;
            parity_error_q   <= 1'b0;
            frame_error_q    <= 1'b0;
            reset_required_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            clk_sync_q       <= clk_sync_d;
            data_sync_q      <= data_sync_d;
            clk_f_q          <= clk_f_d;
            filt_cnt_q       <= filt_cnt_d;
            fall_q           <= fall_d;
            state_q          <= state_d;
            bit_idx_q        <= bit_idx_d;
            shift_q          <= shift_d;
            parity_q         <= parity_d;
            to_cnt_q         <= to_cnt_d;
            data_out_q       <= data_out_d;
            data_valid_q     <= data_valid_d;
            parity_error_q   <= parity_error_d;
            frame_error_q    <= frame_error_d;
            reset_required_q <= reset_required_d;
            busy_q           <= busy_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_valid     = data_valid_q;
    assign parity_error   = parity_error_q;
    assign frame_error    = frame_error_q;
    assign reset_required = reset_required_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed self-checking bench for ps2_receiver: good frames, parity/stop errors, glitch,
// timeout, inhibit and asynchronous reset in the middle of a frame.
module tb_ps2_receiver;

    logic       clk;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       inhibit;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       reset_required;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int        cyc = 0;
    int        dv_cnt = 0, pe_cnt = 0, fe_cnt = 0, rr_cnt = 0;
    logic [7:0] last_dv_data = '0, prev_dv_data = '0;
    int        last_dv_cyc = 0;
    int        stop_fall_cyc = 0;
    logic      prev_pulse = 1'b0;

    ps2_receiver #(
        .FILTER_LEN    (4),
        .TIMEOUT_COUNT (5000),
        .TIMEOUT_WIDTH (13),
        .BAT_CODE      (8'hAA)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .inhibit        (inhibit),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .reset_required (reset_required),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: tallies pulses and checks width, exclusivity and BAT coincidence.
    always @(negedge clk) begin
        if (data_valid || parity_error || frame_error) begin
            check("pulse_exclusive", 32'(data_valid) + 32'(parity_error) + 32'(frame_error), 32'd1);
            check("pulse_width", 32'(prev_pulse), 32'd0);
        end
        if (reset_required) check("rr_with_dv", 32'(data_valid), 32'd1);
        if (data_valid) begin
            dv_cnt++;
            prev_dv_data = last_dv_data;
            last_dv_data = data_out;
            last_dv_cyc  = cyc;
        end
        if (parity_error)   pe_cnt++;
        if (frame_error)    fe_cnt++;
        if (reset_required) rr_cnt++;
        prev_pulse = data_valid | parity_error | frame_error;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first n bits of {stop, parity, data, start}, LSB first, 50-cycle half periods.
    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            wait_cycles(25);
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wait_cycles(50);
            ps2_clk = 1'b1;
            wait_cycles(25);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    int dv0, pe0, fe0, rr0;

    task automatic snap();
        dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt; rr0 = rr_cnt;
    endtask

    initial begin
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        inhibit  = 1'b0;
        wait_cycles(5);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_flags", {27'd0, data_valid, parity_error, frame_error, reset_required, busy}, 32'd0);
        reset_n = 1'b1;
        wait_cycles(10);

        // BAT frame, latency from raw stop fall.
        snap();
        send_bits(mk(8'hAA, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("aa_dv", 32'(dv_cnt - dv0), 32'd1);
        check("aa_rr", 32'(rr_cnt - rr0), 32'd1);
        check("aa_data", 32'(last_dv_data), 32'hAA);
        check("aa_latency", 32'(last_dv_cyc - stop_fall_cyc), 32'd7);
        check("aa_busy", 32'(busy), 32'd0);

        // Back-to-back frames.
        snap();
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
        send_bits(mk(8'hF0, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("b2b_dv", 32'(dv_cnt - dv0), 32'd2);
        check("b2b_first", 32'(prev_dv_data), 32'h1C);
        check("b2b_second", 32'(last_dv_data), 32'hF0);
        check("b2b_rr", 32'(rr_cnt - rr0), 32'd0);

        // Bad parity.
        snap();
        send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("par_pe", 32'(pe_cnt - pe0), 32'd1);
        check("par_dv", 32'(dv_cnt - dv0), 32'd0);
        check("par_data", 32'(data_out), 32'h1C);

        // Bad stop bit.
        snap();
        send_bits(mk(8'h1C, 1'b0, 1'b0), 11);
        wait_cycles(20);
        check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
        check("stop_others", 32'((dv_cnt - dv0) + (pe_cnt - pe0)), 32'd0);

        // 3-cycle glitch in IDLE.
        snap();
        @(negedge clk);
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(20);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_flags", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);

        // Partial frame then timeout; then a clean 0x55.
        snap();
        send_bits(mk(8'h55, 1'b1, 1'b1), 5);
        check("to_busy_mid", 32'(busy), 32'd1);
        for (int i = 0; i < 6000 && fe_cnt == fe0; i++) @(negedge clk);
        check("to_fe", 32'(fe_cnt - fe0), 32'd1);
        wait_cycles(2);
        check("to_busy", 32'(busy), 32'd0);
        check("to_data_kept", 32'(data_out), 32'h1C);
        snap();
        send_bits(mk(8'h55, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("after_to_dv", 32'(dv_cnt - dv0), 32'd1);
        check("after_to_data", 32'(last_dv_data), 32'h55);

        // Inhibit after bit 5 with ps2_clk held low.
        snap();
        send_bits(mk(8'h3C, 1'b1, 1'b1), 7);
        @(negedge clk);
        inhibit = 1'b1;
        ps2_clk = 1'b0;
        wait_cycles(200);
        check("inh_busy", 32'(busy), 32'd0);
        ps2_clk = 1'b1;
        wait_cycles(20);
        inhibit = 1'b0;
        wait_cycles(20);
        check("inh_flags", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);
        snap();
        send_bits(mk(8'hAA, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("inh_aa_dv", 32'(dv_cnt - dv0), 32'd1);
        check("inh_aa_rr", 32'(rr_cnt - rr0), 32'd1);

        // Asynchronous reset while in PARITY.
        snap();
        send_bits(mk(8'h1C, 1'b0, 1'b1), 9);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_data", 32'(data_out), 32'h00);
        check("async_rst_flags", {27'd0, data_valid, parity_error, frame_error, reset_required, busy}, 32'd0);
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(200);
        check("post_rst_flags", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
        wait_cycles(20);
        check("post_rst_dv", 32'(dv_cnt - dv0), 32'd1);
        check("post_rst_data", 32'(data_out), 32'h1C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Receives PS/2 device-to-host frames from the PERIBOARD keyboard and delivers decoded scan-code bytes to the rest of the keyboard FPGA. It sits directly upstream of the keyboard reset sequencer: it generates the single-cycle `reset_required` pulse when the BAT code 0xAA arrives. It also accepts that sequencer's clock-pulldown as an inhibit, so the host's own low drive on ps2_clk is never decoded as keyboard activity.

## Interface
- `FILTER_LEN`, default 4: consecutive clk cycles a new ps2_clk level must hold before it is accepted (glitch filter), ≥2.
- `TIMEOUT_COUNT`, default 5000: clk cycles allowed between falling edges inside a frame before the frame is aborted.
- `TIMEOUT_WIDTH`, default 13: width of the timeout counter; must hold TIMEOUT_COUNT.
- `BAT_CODE`, default 8'hAA: byte that triggers `reset_required`.
- `clk`, input, 1: system clock; one clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `ps2_clk`, input, 1: raw PS/2 clock pin (asynchronous).
- `ps2_data`, input, 1: raw PS/2 data pin (asynchronous).
- `inhibit`, input, 1: host is pulling ps2_clk low (connect to the sequencer's clock pulldown).
- `data_out`, output, 8: last received byte.
- `data_valid`, output, 1: one-cycle pulse, good frame received.
- `parity_error`, output, 1: one-cycle pulse, frame with bad parity.
- `frame_error`, output, 1: one-cycle pulse, bad start, bad stop or timeout.
- `reset_required`, output, 1: one-cycle pulse, coincident with `data_valid` when data_out == BAT_CODE.
- `busy`, output, 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- **Input synchronisation:** ps2_clk and ps2_data each pass through 2 flops, giving clk_s and data_s.
- **Glitch filter:** filtered clock clk_f (resets to 1) plus a counter.
  - Each cycle clk_s ≠ clk_f increments the counter.
  - Any cycle with clk_s == clk_f clears the counter.
  - On the FILTER_LEN-th consecutive mismatch cycle, clk_f ← clk_s and the counter clears.
- **Falling-edge event:** `fall` is high for exactly one cycle, the cycle after clk_f goes 1→0. The FSM samples data_s in that cycle.
- **Frame format:** 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - **IDLE:** on fall with data_s=0, go to DATA with bit index 0. On fall with data_s=1, pulse frame_error and stay in IDLE.
  - **DATA:** on fall, shift data_s into bit[index]. After index 7, go to PARITY.
  - **PARITY:** on fall, latch the parity bit and go to STOP.
  - **STOP, on fall:** data_out ← shift register in all cases, then go to IDLE with:
    - data_s=0: pulse frame_error only.
    - data_s=1 and the 9 bits (data + parity) have odd ones-count: pulse data_valid, plus reset_required if the byte equals BAT_CODE.
    - data_s=1 and even ones-count: pulse parity_error only.
- **Timeout:** the counter clears in IDLE and on every fall, and increments in other states. On reaching TIMEOUT_COUNT: return to IDLE, pulse frame_error, discard partial data; data_out is unchanged.
- **Inhibit:** while `inhibit`=1 the FSM is forced to IDLE, the timeout counter is cleared and fall events are ignored. No error flags are raised. The synchroniser and filter keep running.
- **Priority** (highest first): reset_n, inhibit, fall, timeout. If fall and timeout expiry coincide, the fall is processed and the timeout is discarded.
- **Reset mid-frame:** all state is cleared immediately and asynchronously. There is no spurious pulse after release.

## Timing
- **Reset values:** data_out=8'h00; data_valid, parity_error, frame_error, reset_required and busy all 0; clk_f=1; state IDLE.
- **Registered outputs:** all outputs are registered. The pulses are exactly 1 cycle wide and change on the clk edge ending the fall cycle.
- **Latency:** raw stop-bit fall to data_valid high is 2 (sync) + FILTER_LEN (filter) + 1 (fall/FSM) clk cycles; at default FILTER_LEN this is 7 cycles.
- **Glitches:** a ps2_clk low shorter than FILTER_LEN clk cycles (after sync) produces no fall.
- **busy:** rises in the cycle after the start-bit fall and falls together with the terminating pulse.
- **data_out:** holds its value until the next STOP-state completion.
- **Error exclusivity:** at most one of data_valid, parity_error and frame_error is high in any cycle.
- **Back-to-back frames:** the start bit of the next frame is accepted in the cycle immediately after returning to IDLE.

## Test plan
- Frame 0xAA (parity 1, stop 1), 50 clk cycles per PS/2 half-period, reset_n released → data_out=8'hAA; data_valid and reset_required high for the same single cycle, exactly 7 cycles after the raw stop fall; busy low afterwards.
- Frame 0x1C (parity 0) followed immediately by 0xF0 (parity 1) → two data_valid pulses with data_out 8'h1C then 8'hF0; reset_required never asserted.
- Frame 0x1C with parity 1 → parity_error pulse, data_valid low, data_out=8'h1C. Frame 0x1C with stop 0 → frame_error pulse only.
- 3-cycle low glitch on ps2_clk in IDLE → no state change, no flags. Start plus 4 data bits, then clock held high for 5000 cycles → frame_error at timeout, state IDLE, data_out unchanged; a subsequent full 0x55 frame decodes correctly.
- Inhibit raised mid-frame after bit 5 and ps2_clk held low 200 cycles → no flags, busy=0; a fresh 0xAA frame after inhibit drops gives data_valid and reset_required.
- Assert reset_n low during PARITY state → all outputs 0 asynchronously; no pulse after release; the next frame decodes normally.
